// File: rtl/qea_state_readout.sv
// Reads every row of the QEA state RAM, converts each amplitude to |re|^2+|im|^2,
// and streams (basis index, probability) pairs over valid/ready while summing them.
//
// state   | meaning
// IDLE    | waiting for start; rejects an out-of-range qubit count with o_err
// ISSUE   | one-cycle read request for the current row
// WAIT    | RD_LATENCY cycles for the RAM; probabilities captured on the last one
// EMIT    | hand out PE_NUM pairs of the captured row, one per handshake
// DONE    | one-cycle o_done, then back to IDLE
module qea_state_readout #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_DATA_WIDTH = DATA_WIDTH * 2,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int RD_LATENCY       = 1,
    parameter int IDX_WIDTH        = STATE_ADDR_WIDTH + PE_NUM_WIDTH,
    parameter int SUM_WIDTH        = DATA_WIDTH + IDX_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_err,
    output logic [PE_NUM-1:0]                  o_qea_state_ena,
    output logic [PE_NUM-1:0]                  o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_qea_state_addra,
    input  logic [STATE_DATA_WIDTH*PE_NUM-1:0] i_qea_state_dout,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [IDX_WIDTH-1:0]               o_idx,
    output logic [DATA_WIDTH-1:0]              o_prob,
    output logic [SUM_WIDTH-1:0]               o_prob_sum
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t                      state;
    logic [MAX_QBIT_WIDTH-1:0]   shift;
    logic [STATE_ADDR_WIDTH-1:0] row;
    logic [STATE_ADDR_WIDTH-1:0] last_row;
    logic [PE_NUM_WIDTH-1:0]     k;
    logic [LAT_W-1:0]            lat_cnt;
    logic [SUM_WIDTH-1:0]        sum;
    logic [DATA_WIDTH-1:0]       prob_reg [PE_NUM];
    logic [DATA_WIDTH-1:0]       prob_now [PE_NUM];

    logic [MAX_QBIT_WIDTH-1:0]   qbit_shift;
    logic                        bad_qbit;

    assign qbit_shift = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    assign bad_qbit   = (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) ||
                        (qbit_shift > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH));

    // Each slice is {re, im}; squares are non-negative so the 2*DW+1 sum never goes negative.
    for (genvar j = 0; j < PE_NUM; j++) begin : g_pe
        logic signed [DATA_WIDTH-1:0]   re;
        logic signed [DATA_WIDTH-1:0]   im;
        logic signed [2*DATA_WIDTH-1:0] pr;
        logic signed [2*DATA_WIDTH-1:0] pi;
        logic signed [2*DATA_WIDTH:0]   mag;
        logic signed [2*DATA_WIDTH:0]   scaled;

        assign re     = i_qea_state_dout[(PE_NUM-j)*STATE_DATA_WIDTH-1 -: DATA_WIDTH];
        assign im     = i_qea_state_dout[(PE_NUM-j)*STATE_DATA_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
        assign pr     = (2*DATA_WIDTH)'(re) * (2*DATA_WIDTH)'(re);
        assign pi     = (2*DATA_WIDTH)'(im) * (2*DATA_WIDTH)'(im);
        assign mag    = {pr[2*DATA_WIDTH-1], pr} + {pi[2*DATA_WIDTH-1], pi};
        assign scaled = mag >>> NUM_FRAC_BIT;
        assign prob_now[j] = (|scaled[2*DATA_WIDTH:DATA_WIDTH]) ? '1 : scaled[DATA_WIDTH-1:0];
    end

    assign o_qea_state_wea   = '0;
    assign o_qea_state_addra = row;
    assign o_prob            = prob_reg[k];
    assign o_idx             = (IDX_WIDTH'(k) << shift) | IDX_WIDTH'(row);
    assign o_prob_sum        = sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            shift           <= '0;
            row             <= '0;
            last_row        <= '0;
            k               <= '0;
            lat_cnt         <= '0;
            sum             <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_err           <= 1'b0;
            o_valid         <= 1'b0;
            o_qea_state_ena <= '0;
            for (int j = 0; j < PE_NUM; j++) prob_reg[j] <= '0;
        end else begin
            o_done          <= 1'b0;
            o_err           <= 1'b0;
            o_qea_state_ena <= '0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        sum <= '0;
                        if (bad_qbit) begin
                            o_err <= 1'b1;
                        end else begin
                            shift           <= qbit_shift;
                            last_row        <= ~({STATE_ADDR_WIDTH{1'b1}} << qbit_shift);
                            row             <= '0;
                            k               <= '0;
                            o_busy          <= 1'b1;
                            o_qea_state_ena <= '1;
                            state           <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_W'(RD_LATENCY - 1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        for (int j = 0; j < PE_NUM; j++) prob_reg[j] <= prob_now[j];
                        k       <= '0;
                        o_valid <= 1'b1;
                        state   <= S_EMIT;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_EMIT: begin
                    if (i_ready) begin
                        sum <= sum + SUM_WIDTH'(o_prob);
                        if (k != PE_NUM_WIDTH'(PE_NUM - 1)) begin
                            k <= k + 1'b1;
                        end else begin
                            o_valid <= 1'b0;
                            if (row == last_row) begin
                                o_done <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                row             <= row + 1'b1;
                                o_qea_state_ena <= '1;
                                state           <= S_ISSUE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qea_state_readout.sv
// Scoreboard bench for qea_state_readout: a RAM model feeds amplitudes, a reference
// model queues expected (index, probability) pairs, and a monitor pops them on handshakes.
module tb_qea_state_readout;

    localparam int IDXW = 18;
    localparam int SUMW = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [5:0]        i_qbit_num = '0;
    logic              i_ready = 1'b0;
    logic [255:0]      dout = '0;
    logic              o_busy, o_done, o_err, o_valid;
    logic [3:0]        ena, wea;
    logic [15:0]       addra;
    logic [IDXW-1:0]   o_idx;
    logic [31:0]       o_prob;
    logic [SUMW-1:0]   o_prob_sum;

    qea_state_readout dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (i_start),
        .i_qbit_num        (i_qbit_num),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err),
        .o_qea_state_ena   (ena),
        .o_qea_state_wea   (wea),
        .o_qea_state_addra (addra),
        .i_qea_state_dout  (dout),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_idx             (o_idx),
        .o_prob            (o_prob),
        .o_prob_sum        (o_prob_sum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [31:0]     prob;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] amp_re [64];
    logic [31:0] amp_im [64];
    int          cur_n = 2;
    int          n_vec = 0;
    int          n_err = 0;
    int          ena_cnt = 0;
    int          done_cnt = 0;
    int          pop_cnt = 0;
    int          exp_addr = 0;
    int          rdy_mode = 0;
    logic [SUMW-1:0] model_sum = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Probability from first principles: magnitude squared, drop 30 fraction bits, clamp at 32 bits.
    function automatic logic [31:0] ref_prob(input logic [31:0] re, input logic [31:0] im);
        longint      r = longint'($signed(re));
        longint      i = longint'($signed(im));
        logic [64:0] m;
        m = 65'(r * r) + 65'(i * i);
        m = m >> 30;
        if (m >= 65'h1_0000_0000) return 32'hFFFF_FFFF;
        return m[31:0];
    endfunction

    function automatic logic [255:0] row_word(input logic [15:0] a);
        logic [255:0] w = '0;
        for (int k = 0; k < 4; k++) begin
            int idx = ((k << (cur_n - 2)) | int'(a)) & 63;
            w[(4-k)*64-1 -: 64] = {amp_re[idx], amp_im[idx]};
        end
        return w;
    endfunction

    // State RAM with one cycle of read latency.
    always @(posedge clk) if (|ena) dout <= row_word(addra);

    initial begin : ready_drv
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pair", 64'(o_idx), 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("idx", 64'(o_idx), 64'(e.idx));
                        check("prob", 64'(o_prob), 64'(e.prob));
                        model_sum = model_sum + SUMW'(e.prob);
                        pop_cnt++;
                    end
                end
                if (|ena) begin
                    ena_cnt++;
                    check("ena_all", 64'(ena), 64'hF);
                    check("addra", 64'(addra), 64'(exp_addr));
                    check("wea", 64'(wea), 64'h0);
                    exp_addr++;
                end
                if (o_done) begin
                    done_cnt++;
                    check("prob_sum", 64'(o_prob_sum), 64'(model_sum));
                end
            end
        end
    end

    task automatic prepare(input int n, input int fill);
        int rows = 1 << (n - 2);
        exp_t e;
        cur_n = n;
        for (int i = 0; i < 64; i++) begin
            case (fill)
                0: begin amp_re[i] = (i == 0) ? 32'h4000_0000 : 32'h0; amp_im[i] = 32'h0; end
                1: begin amp_re[i] = 32'h0B50_4F33; amp_im[i] = 32'h0; end
                default: begin
                    amp_re[i] = 32'($signed($urandom) >>> $urandom_range(0, 6));
                    amp_im[i] = 32'($signed($urandom) >>> $urandom_range(0, 6));
                end
            endcase
        end
        if (fill == 3) begin
            amp_re[5] = 32'h7FFF_FFFF;
            amp_im[5] = 32'h7FFF_FFFF;
        end
        exp_q.delete();
        for (int r = 0; r < rows; r++)
            for (int k = 0; k < 4; k++) begin
                e.idx  = IDXW'(k * rows + r);
                e.prob = ref_prob(amp_re[k * rows + r], amp_im[k * rows + r]);
                exp_q.push_back(e);
            end
        model_sum = '0;
        ena_cnt   = 0;
        done_cnt  = 0;
        pop_cnt   = 0;
        exp_addr  = 0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1;
        i_start    = 1'b1;
        i_qbit_num = 6'(n);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run_full(input int n, input int fill, input int mode, input bit dup);
        prepare(n, fill);
        rdy_mode = mode;
        pulse_start(n);
        if (dup) begin
            repeat (3) @(posedge clk);
            pulse_start(n);
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done_cnt != 0) break;
        end
        repeat (3) @(negedge clk);
        check("pairs_left", 64'(exp_q.size()), 64'h0);
        check("done_count", 64'(done_cnt), 64'h1);
        check("ena_count", 64'(ena_cnt), 64'(1 << (n - 2)));
        check("busy_after", 64'(o_busy), 64'h0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(o_busy), 64'h0);
        check({tag, "_done"}, 64'(o_done), 64'h0);
        check({tag, "_err"}, 64'(o_err), 64'h0);
        check({tag, "_valid"}, 64'(o_valid), 64'h0);
        check({tag, "_ena"}, 64'(ena), 64'h0);
        check({tag, "_wea"}, 64'(wea), 64'h0);
        check({tag, "_addra"}, 64'(addra), 64'h0);
        check({tag, "_idx"}, 64'(o_idx), 64'h0);
        check({tag, "_prob"}, 64'(o_prob), 64'h0);
        check({tag, "_sum"}, 64'(o_prob_sum), 64'h0);
    endtask

    task automatic bad_start(input int n);
        ena_cnt = 0;
        pulse_start(n);
        @(negedge clk);
        check("err_pulse", 64'(o_err), 64'h1);
        check("err_busy", 64'(o_busy), 64'h0);
        @(negedge clk);
        check("err_one_cycle", 64'(o_err), 64'h0);
        repeat (4) @(negedge clk);
        check("err_no_ena", 64'(ena_cnt), 64'h0);
        check("err_still_idle", 64'(o_busy), 64'h0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        run_full(5, 0, 0, 1'b0);
        run_full(5, 1, 0, 1'b0);
        run_full(3, 3, 0, 1'b0);
        run_full(5, 2, 1, 1'b1);
        for (int it = 0; it < 4; it++)
            run_full(int'($urandom_range(2, 6)), 2, 2, 1'b0);

        bad_start(1);
        bad_start(19);

        // Abort part-way through row 3, then confirm a fresh run starts clean.
        prepare(5, 2);
        rdy_mode = 0;
        pulse_start(5);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (pop_cnt >= 13) break;
        end
        check("reached_row3", 64'(pop_cnt >= 13), 64'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        check("abort_no_done", 64'(done_cnt), 64'h0);
        run_full(3, 2, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
